// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N:1 stream multiplexer.
// Optional channel mask: define MUX_CH_MASK_EN.
package mux_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Upper bound on channel count supported by the mask search.
    localparam int MAXCH = 64;

    // Next enabled channel after cur, searching cur+1, cur+2, ... with
    // wrap at nch. Returns cur unchanged when no channel is enabled.
    function automatic int next_ch(input int cur,
                                   input logic [MAXCH-1:0] mask,
                                   input int nch);
        int  res;
        int  idx;
        bit  found;
        res   = cur;
        found = 1'b0;
        for (int i = 1; i <= MAXCH; i++) begin
            idx = cur + i;
            if (idx >= nch) idx = idx - nch;
            if (!found && i <= nch && idx < MAXCH) begin
                if (mask[idx]) begin
                    res   = idx;
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux_scan_ctr.sv
// Scan counter, registered mode and scan-entry detect.
// Optional channel mask: define MUX_CH_MASK_EN.
module mux_scan_ctr
    import mux_pkg::*;
#(
    parameter int NCH  = 8,
    parameter int SELW = $clog2(NCH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode_i,
    input  logic            cap_i,
`ifdef MUX_CH_MASK_EN
    input  logic [NCH-1:0]  ch_en_i,
`endif
    output logic [SELW-1:0] ch_o,
    output logic            any_en_o
);

    logic [SELW-1:0]  cnt_q, cnt_d;
    logic             mode_q;
    logic             entry;
    logic [MAXCH-1:0] mask;

    // Widen the enable mask to the search width used by next_ch.
    always_comb begin
        mask = '0;
`ifdef MUX_CH_MASK_EN
        mask[NCH-1:0] = ch_en_i;
`else
        mask[NCH-1:0] = '1;
`endif
    end

    assign any_en_o = |mask;
    assign entry    = (mode_i == MODE_SCAN) && (mode_q == MODE_DIRECT);

    // On scan entry the channel restarts at the lowest enabled index.
    always_comb begin
        if (entry) ch_o = SELW'(next_ch(NCH - 1, mask, NCH));
        else       ch_o = cnt_q;
    end

    // Step on a scan capture; otherwise latch the active channel so an
    // entry cycle without a capture still leaves the counter at its start.
    always_comb begin
        cnt_d = cnt_q;
        if (mode_i == MODE_SCAN) begin
            if (cap_i) cnt_d = SELW'(next_ch(int'(ch_o), mask, NCH));
            else       cnt_d = ch_o;
        end
    end

    // Counter and mode history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            mode_q <= MODE_DIRECT;
        end else begin
            cnt_q  <= cnt_d;
            mode_q <= mode_i;
        end
    end

endmodule

// File: rtl/mux_nto1_stream.sv
// N-channel registered mux with a valid/ready output stage.
// Optional channel mask: define MUX_CH_MASK_EN.
module mux_nto1_stream
    import mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 8,
    parameter int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] d,
    input  logic [SELW-1:0]      sel,
    input  logic                 mode,
`ifdef MUX_CH_MASK_EN
    input  logic [NCH-1:0]       ch_en,
`endif
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     y,
    output logic [SELW-1:0]      y_ch,
    output logic                 y_err,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [WIDTH-1:0] y_q, y_d;
    logic [SELW-1:0]  ych_q, ych_d;
    logic             err_q, err_d;
    logic             ov_q, ov_d;

    logic [SELW-1:0]  scan_ch;
    logic             any_en;
    logic [SELW-1:0]  ch;
    logic [31:0]      ch_ext;
    logic [WIDTH-1:0] data;
    logic             ch_ok;
    logic             fire;

    mux_scan_ctr #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_scan (
        .clk      (clk),
        .rst      (rst),
        .mode_i   (mode),
        .cap_i    (fire),
`ifdef MUX_CH_MASK_EN
        .ch_en_i  (ch_en),
`endif
        .ch_o     (scan_ch),
        .any_en_o (any_en)
    );

    assign ch     = (mode == MODE_SCAN) ? scan_ch : sel;
    assign ch_ext = 32'(ch);

    // A scan with nothing enabled must not capture.
    assign in_ready = (~ov_q | out_ready)
                    & ~((mode == MODE_SCAN) & ~any_en);
    assign fire     = in_valid & in_ready;

    // Data select; out-of-range or disabled channels yield zero.
    always_comb begin
        data  = '0;
        ch_ok = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (ch_ext == 32'(k)) begin
`ifdef MUX_CH_MASK_EN
                ch_ok = ch_en[k];
`else
                ch_ok = 1'b1;
`endif
                if (ch_ok) data = d[k*WIDTH +: WIDTH];
            end
        end
    end

    // Output stage: load on capture, drop valid when drained, else hold.
    always_comb begin
        y_d   = y_q;
        ych_d = ych_q;
        err_d = err_q;
        ov_d  = ov_q;
        if (fire) begin
            y_d   = data;
            ych_d = ch;
            err_d = ~ch_ok;
            ov_d  = 1'b1;
        end else if (ov_q && out_ready) begin
            ov_d  = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q   <= '0;
            ych_q <= '0;
            err_q <= 1'b0;
            ov_q  <= 1'b0;
        end else begin
            y_q   <= y_d;
            ych_q <= ych_d;
            err_q <= err_d;
            ov_q  <= ov_d;
        end
    end

    assign y         = y_q;
    assign y_ch      = ych_q;
    assign y_err     = err_q;
    assign out_valid = ov_q;

endmodule

// File: tb/tb_mux_nto1_stream.sv
// Directed bench for mux_nto1_stream (NCH=8 and NCH=6 instances).
// Mask tests run when MUX_CH_MASK_EN is defined.
module tb_mux_nto1_stream;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // NCH=8 instance
    logic        rst;
    logic [63:0] d;
    logic [2:0]  sel;
    logic        mode, in_valid, in_ready;
    logic [7:0]  y;
    logic [2:0]  y_ch;
    logic        y_err, out_valid, out_ready;
`ifdef MUX_CH_MASK_EN
    logic [7:0]  ch_en;
`endif

    // NCH=6 instance
    logic        rst6;
    logic [47:0] d6;
    logic [2:0]  sel6;
    logic        mode6, iv6, ir6;
    logic [7:0]  y6;
    logic [2:0]  ych6;
    logic        err6, ov6, or6;
`ifdef MUX_CH_MASK_EN
    logic [5:0]  ch_en6;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    mux_nto1_stream #(.WIDTH(8), .NCH(8)) dut (
        .clk(clk), .rst(rst), .d(d), .sel(sel), .mode(mode),
`ifdef MUX_CH_MASK_EN
        .ch_en(ch_en),
`endif
        .in_valid(in_valid), .in_ready(in_ready),
        .y(y), .y_ch(y_ch), .y_err(y_err),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_nto1_stream #(.WIDTH(8), .NCH(6)) dut6 (
        .clk(clk), .rst(rst6), .d(d6), .sel(sel6), .mode(mode6),
`ifdef MUX_CH_MASK_EN
        .ch_en(ch_en6),
`endif
        .in_valid(iv6), .in_ready(ir6),
        .y(y6), .y_ch(ych6), .y_err(err6),
        .out_valid(ov6), .out_ready(or6)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 8; k++) d[k*8 +: 8] = 8'h10 + 8'(k);
        for (int k = 0; k < 6; k++) d6[k*8 +: 8] = 8'hA0 + 8'(k);
`ifdef MUX_CH_MASK_EN
        ch_en  = 8'hFF;
        ch_en6 = 6'h3F;
`endif
        rst = 1'b1; sel = 3'd0; mode = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;
        rst6 = 1'b1; sel6 = 3'd0; mode6 = 1'b0;
        iv6 = 1'b0; or6 = 1'b1;
        step(); step();
        rst = 1'b0; rst6 = 1'b0;
        chk("rst_y", 32'(y), 0);
        chk("rst_ych", 32'(y_ch), 0);
        chk("rst_err", 32'(y_err), 0);
        chk("rst_ov", 32'(out_valid), 0);

        // 1: direct capture, one-cycle latency
        sel = 3'd5; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t1_y", 32'(y), 32'h15);
        chk("t1_ych", 32'(y_ch), 5);
        chk("t1_err", 32'(y_err), 0);
        chk("t1_ov", 32'(out_valid), 1);
        step();
        chk("t1_drain", 32'(out_valid), 0);

        // 2: scan streaming, no bubbles
        mode = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t2_ych", 32'(y_ch), 32'(i % 8));
            chk("t2_y", 32'(y), 32'h10 + 32'(i % 8));
            chk("t2_ov", 32'(out_valid), 1);
        end

        // 3: backpressure holds word 1, then load in same cycle
        out_ready = 1'b0;
        #1;
        chk("t3_ir0", 32'(in_ready), 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_hold_y", 32'(y), 32'h11);
            chk("t3_hold_ov", 32'(out_valid), 1);
        end
        out_ready = 1'b1;
        #1;
        chk("t3_ir1", 32'(in_ready), 1);
        step();
        chk("t3_next_ych", 32'(y_ch), 2);
        chk("t3_next_y", 32'(y), 32'h12);
        in_valid = 1'b0;
        step();
        chk("t3_ov0", 32'(out_valid), 0);

        // 4: NCH=6 out-of-range select
        sel6 = 3'd7; iv6 = 1'b1;
        step();
        chk("t4_y_oor", 32'(y6), 0);
        chk("t4_ych_oor", 32'(ych6), 7);
        chk("t4_err_oor", 32'(err6), 1);
        sel6 = 3'd3;
        step();
        iv6 = 1'b0;
        chk("t4_y3", 32'(y6), 32'hA3);
        chk("t4_err3", 32'(err6), 0);

        // 5: scan 0..2, direct x2, scan re-entry starts at 0
        mode = 1'b0;
        step();
        mode = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_scan", 32'(y_ch), 32'(i));
        end
        mode = 1'b0; sel = 3'd6;
        step();
        chk("t5_dir6", 32'(y_ch), 6);
        sel = 3'd3;
        step();
        chk("t5_dir3", 32'(y), 32'h13);
        mode = 1'b1;
        step();
        chk("t5_reentry", 32'(y_ch), 0);
        chk("t5_reentry_y", 32'(y), 32'h10);
        out_ready = 1'b0; mode = 1'b0; sel = 3'd4;
        step();
        chk("t5_stall_sel", 32'(y_ch), 0);
        chk("t5_stall_y", 32'(y), 32'h10);
        rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("t5_rst_ov", 32'(out_valid), 0);
        chk("t5_rst_y", 32'(y), 0);

`ifdef MUX_CH_MASK_EN
        // 6: masked scan and empty mask
        ch_en = 8'b1010_0100;
        rst = 1'b1;
        step();
        rst = 1'b0; mode = 1'b1; in_valid = 1'b1;
        step(); chk("t6_a", 32'(y_ch), 2);
        step(); chk("t6_b", 32'(y_ch), 5);
        step(); chk("t6_c", 32'(y_ch), 7);
        step(); chk("t6_d", 32'(y_ch), 2);
        ch_en = 8'h00;
        #1;
        chk("t6_ir0", 32'(in_ready), 0);
        step();
        chk("t6_nocap", 32'(out_valid), 0);
        in_valid = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
